os_drain_ctrl: RTL

Parametrised output-stage controller for the multiplier datapath. When the top-level FSM reaches DONE, it pops a snapshot-counted number of RES_W-bit results from the result FIFO, optionally splits each into DATA_W beats, and presents them on a valid/ready output port. It can optionally write each popped entry back to the FIFO (recirculate mode), and pulses `multi_opdone` exactly once per DONE visit. It sits between the result FIFO and the bus-facing output register.

---
 rtl/os_pkg.sv | 24 ++
 rtl/os_drain_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/os_pkg.sv
// Shared encodings for the output-stage drain controller: top FSM states,
// beat-select modes and the controller's own state enum.
package os_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [1:0] MODE_LO   = 2'b00;
  localparam logic [1:0] MODE_HI   = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam int         RECIRC_BIT = 2;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_READ  = 3'd1,
    C_WAIT  = 3'd2,
    C_BEAT0 = 3'd3,
    C_BEAT1 = 3'd4,
    C_NEXT  = 3'd5,
    C_FIN   = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/os_drain_ctrl.sv
// Drains a snapshot-counted number of FIFO results onto a valid/ready beat port
// once per DONE visit, optionally writing each entry back to the FIFO.
module os_drain_ctrl
  import os_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RES_W  = 64,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic [2:0]        mode,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic [RES_W-1:0]  result_in,
  output logic              fifo_re,
  output logic              fifo_we,
  output logic [RES_W-1:0]  fifo_wdata,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              multi_opdone,
  output logic              busy
);

  ctrl_state_e       st_q, st_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [2:0]        mode_q, mode_d;
  logic              done_seen_q, done_seen_d;
  logic [RES_W-1:0]  hold_q, hold_d;

  logic              fifo_re_q, fifo_re_d;
  logic              fifo_we_q, fifo_we_d;
  logic [RES_W-1:0]  fifo_wdata_q, fifo_wdata_d;
  logic [DATA_W-1:0] result_out_q, result_out_d;
  logic              result_valid_q, result_valid_d;
  logic              multi_opdone_q, multi_opdone_d;
  logic              busy_q, busy_d;

  logic              in_done;
  logic [1:0]        beat_sel;

  assign in_done  = (state == ST_DONE);
  // The reserved select code behaves exactly like the low-half select.
  assign beat_sel = (mode[1:0] == 2'b11) ? MODE_LO : mode[1:0];

  // Next-state, snapshot and hold logic; outputs are decoded from the next state
  // so every port is a plain register aligned with the controller state.
  always_comb begin
    st_d         = st_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    hold_d       = hold_q;
    done_seen_d  = done_seen_q;
    result_out_d = result_out_q;

    case (st_q)
      C_IDLE: begin
        if (in_done && !done_seen_q) begin
          rem_d  = (fifo_data_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : fifo_data_count;
          mode_d = {mode[RECIRC_BIT], beat_sel};
          st_d   = (rem_d == {CNT_W{1'b0}}) ? C_FIN : C_READ;
        end else begin
          st_d = C_IDLE;
        end
      end
      C_READ: begin
        st_d = in_done ? C_WAIT : C_IDLE;
      end
      C_WAIT: begin
        if (in_done) begin
          hold_d       = result_in;
          result_out_d = (mode_q[1:0] == MODE_HI) ? result_in[RES_W-1:DATA_W]
                                                  : result_in[DATA_W-1:0];
          st_d         = C_BEAT0;
        end else begin
          st_d = C_IDLE;
        end
      end
      C_BEAT0: begin
        if (!in_done) begin
          st_d = C_IDLE;
        end else if (result_ready && (mode_q[1:0] == MODE_BOTH)) begin
          result_out_d = hold_q[RES_W-1:DATA_W];
          st_d         = C_BEAT1;
        end else if (result_ready) begin
          st_d = C_NEXT;
        end else begin
          st_d = C_BEAT0;
        end
      end
      C_BEAT1: begin
        if (!in_done) begin
          st_d = C_IDLE;
        end else if (result_ready) begin
          st_d = C_NEXT;
        end else begin
          st_d = C_BEAT1;
        end
      end
      C_NEXT: begin
        rem_d = rem_q - CNT_W'(1);
        if (!in_done) begin
          st_d = C_IDLE;
        end else if (rem_q == CNT_W'(1)) begin
          st_d = C_FIN;
        end else begin
          st_d = C_READ;
        end
      end
      C_FIN: begin
        done_seen_d = 1'b1;
        st_d        = C_IDLE;
      end
      default: begin
        st_d = C_IDLE;
      end
    endcase

    // Leaving DONE re-arms the controller for the next visit.
    done_seen_d    = in_done ? done_seen_d : 1'b0;

    fifo_re_d      = (st_d == C_READ);
    fifo_we_d      = (st_d == C_NEXT) && mode_q[RECIRC_BIT];
    fifo_wdata_d   = fifo_we_d ? hold_q : fifo_wdata_q;
    result_valid_d = (st_d == C_BEAT0) || (st_d == C_BEAT1);
    multi_opdone_d = (st_d == C_FIN);
    busy_d         = (st_d != C_IDLE);
  end

  // State, snapshot and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q           <= C_IDLE;
      rem_q          <= {CNT_W{1'b0}};
      mode_q         <= 3'b000;
      done_seen_q    <= 1'b0;
      hold_q         <= {RES_W{1'b0}};
      fifo_re_q      <= 1'b0;
      fifo_we_q      <= 1'b0;
      fifo_wdata_q   <= {RES_W{1'b0}};
      result_out_q   <= {DATA_W{1'b0}};
      result_valid_q <= 1'b0;
      multi_opdone_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      st_q           <= st_d;
      rem_q          <= rem_d;
      mode_q         <= mode_d;
      done_seen_q    <= done_seen_d;
      hold_q         <= hold_d;
      fifo_re_q      <= fifo_re_d;
      fifo_we_q      <= fifo_we_d;
      fifo_wdata_q   <= fifo_wdata_d;
      result_out_q   <= result_out_d;
      result_valid_q <= result_valid_d;
      multi_opdone_q <= multi_opdone_d;
      busy_q         <= busy_d;
    end
  end

  assign fifo_re      = fifo_re_q;
  assign fifo_we      = fifo_we_q;
  assign fifo_wdata   = fifo_wdata_q;
  assign result_out   = result_out_q;
  assign result_valid = result_valid_q;
  assign multi_opdone = multi_opdone_q;
  assign busy         = busy_q;

endmodule
